playback_sequencer: RTL and testbench

Front-end controller for the beat-indexed player. Turns single-cycle user command pulses (play/pause, loop, loop width, reverse, tempo) into a beat-aligned, glitch-free control bundle for the player datapath. It also generates the beat strobe that advances the player's beat index. It sits between the one-pulse button conditioning and the player; all player mode changes are sequenced here so they land on beat boundaries.

---
 rtl/playback_sequencer.sv | 172 +++++++++++++++++
 tb/tb_playback_sequencer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/playback_sequencer.sv
// playback_sequencer: turns one-cycle user command pulses into a
// beat-aligned control bundle for the beat-indexed player, and generates
// the beat strobe that advances the player's beat index.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   PAUSE | stopped; beat counter held at 0, reverse toggles at once
//   PLAY  | counting beats, no loop
//   ARM   | loop requested; becomes LOOP on the next beat strobe
//   LOOP  | looping; loop width frozen
module playback_sequencer #(
  parameter int DIV_W    = 26,
  parameter int BEAT_DIV = 25_000_000,
  parameter int MIN_DIV  = 6_250_000,
  parameter int MAX_DIV  = 50_000_000,
  parameter int DIV_STEP = 3_125_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_play,
  input  logic             btn_loop,
  input  logic             btn_width,
  input  logic             btn_rev,
  input  logic             btn_faster,
  input  logic             btn_slower,
  output logic             beat_en,
  output logic             play_pause,
  output logic             loop_de,
  output logic [2:0]       loop_width,
  output logic             reverse,
  output logic [1:0]       state,
  output logic [DIV_W-1:0] tempo_div
);

  localparam logic [1:0] ST_PAUSE = 2'd0;
  localparam logic [1:0] ST_PLAY  = 2'd1;
  localparam logic [1:0] ST_ARM   = 2'd2;
  localparam logic [1:0] ST_LOOP  = 2'd3;

  localparam logic [DIV_W-1:0] BEAT_C   = DIV_W'(BEAT_DIV);
  localparam logic [DIV_W-1:0] MIN_C    = DIV_W'(MIN_DIV);
  localparam logic [DIV_W-1:0] MAX_C    = DIV_W'(MAX_DIV);
  localparam logic [DIV_W-1:0] STEP_C   = DIV_W'(DIV_STEP);
  // Thresholds at which a step would cross the saturation limits.
  localparam logic [DIV_W-1:0] FAST_LIM = DIV_W'(MIN_DIV + DIV_STEP);
  localparam logic [DIV_W-1:0] SLOW_LIM = DIV_W'(MAX_DIV - DIV_STEP);
  localparam logic [DIV_W-1:0] ONE_C    = DIV_W'(1);

  logic [1:0]       state_q, state_d;
  logic             beat_en_q, beat_en_d;
  logic             play_pause_q, play_pause_d;
  logic             loop_de_q, loop_de_d;
  logic [2:0]       loop_width_q, loop_width_d;
  logic             reverse_q, reverse_d;
  logic             rev_pend_q, rev_pend_d;
  logic [DIV_W-1:0] tempo_div_q, tempo_div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             run;

  // Next-state decode; btn_play has priority over btn_loop everywhere.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_PAUSE: if (btn_play) state_d = ST_PLAY;
      ST_PLAY: begin
        if (btn_play)      state_d = ST_PAUSE;
        else if (btn_loop) state_d = ST_ARM;
      end
      ST_ARM: begin
        if (btn_play)       state_d = ST_PAUSE;
        else if (btn_loop)  state_d = ST_PLAY;
        else if (beat_en_q) state_d = ST_LOOP;
      end
      ST_LOOP: begin
        if (btn_play)      state_d = ST_PAUSE;
        else if (btn_loop) state_d = ST_PLAY;
      end
      default: state_d = ST_PAUSE;
    endcase
    play_pause_d = (state_d != ST_PAUSE);
    loop_de_d    = (state_d == ST_LOOP);
  end

  // Beat counter: counts only while playing in both this and the next cycle,
  // so the first beat lands tempo_div cycles after play and pause never
  // lets a stray strobe through. The >= compare catches tempo shrinks.
  always_comb begin
    run       = (state_q != ST_PAUSE) && (state_d != ST_PAUSE);
    cnt_d     = '0;
    beat_en_d = 1'b0;
    if (run) begin
      if (cnt_q >= tempo_div_q - ONE_C) begin
        beat_en_d = 1'b1;
      end else begin
        cnt_d = cnt_q + ONE_C;
      end
    end
  end

  // Tempo divider with saturation; simultaneous faster/slower cancel.
  always_comb begin
    tempo_div_d = tempo_div_q;
    if (btn_faster && !btn_slower) begin
      tempo_div_d = (tempo_div_q <= FAST_LIM) ? MIN_C : tempo_div_q - STEP_C;
    end else if (btn_slower && !btn_faster) begin
      tempo_div_d = (tempo_div_q >= SLOW_LIM) ? MAX_C : tempo_div_q + STEP_C;
    end
  end

  // Loop width cycles 1..4 but stays frozen while the player is looping.
  always_comb begin
    loop_width_d = loop_width_q;
    if (btn_width && (state_q != ST_LOOP)) begin
      loop_width_d = (loop_width_q >= 3'd4) ? 3'd1 : loop_width_q + 3'd1;
    end
  end

  // Direction: immediate in PAUSE, otherwise deferred to the next beat so a
  // beat is never split; leaving for PAUSE flushes any pending toggle.
  always_comb begin
    reverse_d  = reverse_q;
    rev_pend_d = rev_pend_q;
    if (state_q == ST_PAUSE) begin
      reverse_d  = reverse_q ^ btn_rev;
      rev_pend_d = 1'b0;
    end else begin
      if (beat_en_q) begin
        reverse_d  = reverse_q ^ rev_pend_q;
        rev_pend_d = 1'b0;
      end
      rev_pend_d = rev_pend_d ^ btn_rev;
      if (state_d == ST_PAUSE) begin
        reverse_d  = reverse_d ^ rev_pend_d;
        rev_pend_d = 1'b0;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_PAUSE;
      beat_en_q    <= 1'b0;
      play_pause_q <= 1'b0;
      loop_de_q    <= 1'b0;
      loop_width_q <= 3'd1;
      reverse_q    <= 1'b0;
      rev_pend_q   <= 1'b0;
      tempo_div_q  <= BEAT_C;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      beat_en_q    <= beat_en_d;
      play_pause_q <= play_pause_d;
      loop_de_q    <= loop_de_d;
      loop_width_q <= loop_width_d;
      reverse_q    <= reverse_d;
      rev_pend_q   <= rev_pend_d;
      tempo_div_q  <= tempo_div_d;
      cnt_q        <= cnt_d;
    end
  end

  assign state      = state_q;
  assign beat_en    = beat_en_q;
  assign play_pause = play_pause_q;
  assign loop_de    = loop_de_q;
  assign loop_width = loop_width_q;
  assign reverse    = reverse_q;
  assign tempo_div  = tempo_div_q;

endmodule

// File: tb/tb_playback_sequencer.sv
// Testbench for playback_sequencer with BEAT_DIV=8, MIN_DIV=4, MAX_DIV=12,
// DIV_STEP=2. Expected beat cycles go into a queue and a negedge monitor
// pops them as the strobe appears.
module tb_playback_sequencer;

  localparam int DIV_W = 26;

  localparam logic [5:0] B_PLAY  = 6'b000001;
  localparam logic [5:0] B_LOOP  = 6'b000010;
  localparam logic [5:0] B_WIDTH = 6'b000100;
  localparam logic [5:0] B_REV   = 6'b001000;
  localparam logic [5:0] B_FAST  = 6'b010000;
  localparam logic [5:0] B_SLOW  = 6'b100000;

  typedef struct {
    logic [5:0]       btn;
    logic [1:0]       st;
    logic             pp;
    logic             ld;
    logic [2:0]       lw;
    logic             rev;
    logic [DIV_W-1:0] td;
  } vec_t;

  logic             clk;
  logic             rst;
  logic [5:0]       btns;
  logic             beat_en;
  logic             play_pause;
  logic             loop_de;
  logic [2:0]       loop_width;
  logic             reverse;
  logic [1:0]       state;
  logic [DIV_W-1:0] tempo_div;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit mon_en  = 1'b0;
  int exp_beats[$];
  vec_t vec[23];

  playback_sequencer #(
    .DIV_W(DIV_W), .BEAT_DIV(8), .MIN_DIV(4), .MAX_DIV(12), .DIV_STEP(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_play(btns[0]),
    .btn_loop(btns[1]),
    .btn_width(btns[2]),
    .btn_rev(btns[3]),
    .btn_faster(btns[4]),
    .btn_slower(btns[5]),
    .beat_en(beat_en),
    .play_pause(play_pause),
    .loop_de(loop_de),
    .loop_width(loop_width),
    .reverse(reverse),
    .state(state),
    .tempo_div(tempo_div)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Beat scoreboard: every strobe must match the head of the queue.
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_beats.size() > 0 && exp_beats[0] == cyc) begin
        chk("beat_en at scheduled cycle", 32'(beat_en), 32'd1);
        void'(exp_beats.pop_front());
      end else if (exp_beats.size() > 0 && exp_beats[0] < cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL beat schedule: expected beat at cycle %0d not checked, now %0d",
                 exp_beats[0], cyc);
        void'(exp_beats.pop_front());
      end else if (beat_en) begin
        n_tests++;
        n_fail++;
        $display("FAIL beat_en unexpected: got 1, want 0 (cycle %0d)", cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic pulse(input logic [5:0] b);
    btns = b;
    step();
    btns = '0;
  endtask

  task automatic sched(input int start, input int period, input int count);
    for (int k = 1; k <= count; k++) exp_beats.push_back(start + period * k);
  endtask

  function automatic vec_t mk(input logic [5:0] b, input logic [1:0] st, input logic pp,
                              input logic ld, input logic [2:0] lw, input logic rev,
                              input int td);
    vec_t v;
    v.btn = b; v.st = st; v.pp = pp; v.ld = ld; v.lw = lw; v.rev = rev;
    v.td  = DIV_W'(td);
    return v;
  endfunction

  initial begin
    int p0;
    int p;
    int q0;
    int t_play;

    vec[0]  = mk(B_FAST,          2'd0, 1'b0, 1'b0, 3'd1, 1'b0, 6);
    vec[1]  = mk(B_FAST,          2'd0, 1'b0, 1'b0, 3'd1, 1'b0, 4);
    vec[2]  = mk(B_FAST,          2'd0, 1'b0, 1'b0, 3'd1, 1'b0, 4);
    vec[3]  = mk(B_SLOW,          2'd0, 1'b0, 1'b0, 3'd1, 1'b0, 6);
    vec[4]  = mk(B_SLOW,          2'd0, 1'b0, 1'b0, 3'd1, 1'b0, 8);
    vec[5]  = mk(B_SLOW,          2'd0, 1'b0, 1'b0, 3'd1, 1'b0, 10);
    vec[6]  = mk(B_SLOW,          2'd0, 1'b0, 1'b0, 3'd1, 1'b0, 12);
    vec[7]  = mk(B_SLOW,          2'd0, 1'b0, 1'b0, 3'd1, 1'b0, 12);
    vec[8]  = mk(B_FAST,          2'd0, 1'b0, 1'b0, 3'd1, 1'b0, 10);
    vec[9]  = mk(B_FAST,          2'd0, 1'b0, 1'b0, 3'd1, 1'b0, 8);
    vec[10] = mk(B_REV,           2'd0, 1'b0, 1'b0, 3'd1, 1'b1, 8);
    vec[11] = mk(B_REV,           2'd0, 1'b0, 1'b0, 3'd1, 1'b0, 8);
    vec[12] = mk(B_WIDTH,         2'd0, 1'b0, 1'b0, 3'd2, 1'b0, 8);
    vec[13] = mk(B_WIDTH,         2'd0, 1'b0, 1'b0, 3'd3, 1'b0, 8);
    vec[14] = mk(B_WIDTH,         2'd0, 1'b0, 1'b0, 3'd4, 1'b0, 8);
    vec[15] = mk(B_WIDTH,         2'd0, 1'b0, 1'b0, 3'd1, 1'b0, 8);
    vec[16] = mk(B_PLAY | B_LOOP, 2'd1, 1'b1, 1'b0, 3'd1, 1'b0, 8);
    vec[17] = mk(B_WIDTH,         2'd1, 1'b1, 1'b0, 3'd2, 1'b0, 8);
    vec[18] = mk(B_WIDTH,         2'd1, 1'b1, 1'b0, 3'd3, 1'b0, 8);
    vec[19] = mk(B_WIDTH,         2'd1, 1'b1, 1'b0, 3'd4, 1'b0, 8);
    vec[20] = mk(B_WIDTH,         2'd1, 1'b1, 1'b0, 3'd1, 1'b0, 8);
    vec[21] = mk(B_WIDTH,         2'd1, 1'b1, 1'b0, 3'd2, 1'b0, 8);
    vec[22] = mk(B_FAST | B_SLOW, 2'd1, 1'b1, 1'b0, 3'd2, 1'b0, 8);

    rst  = 1'b0;
    btns = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset state",      32'(state),      32'd0);
    chk("reset play_pause", 32'(play_pause), 32'd0);
    chk("reset loop_de",    32'(loop_de),    32'd0);
    chk("reset loop_width", 32'(loop_width), 32'd1);
    chk("reset reverse",    32'(reverse),    32'd0);
    chk("reset tempo_div",  32'(tempo_div),  32'd8);
    chk("reset beat_en",    32'(beat_en),    32'd0);
    rst = 1'b1;
    idle(2);
    mon_en = 1'b1;

    // Play: beats every 8 cycles, pause stops them and clears the counter.
    pulse(B_PLAY);
    p0 = cyc;
    chk("play state",      32'(state),      32'd1);
    chk("play play_pause", 32'(play_pause), 32'd1);
    chk("play loop_de",    32'(loop_de),    32'd0);
    sched(p0, 8, 3);
    idle(26);
    pulse(B_PLAY);
    chk("pause state",      32'(state),      32'd0);
    chk("pause play_pause", 32'(play_pause), 32'd0);
    chk("pause cnt",        32'(dut.cnt_q),  32'd0);
    idle(12);
    chk("pause beats drained", 32'(exp_beats.size()), 32'd0);

    // Table: tempo saturation, reverse and width in PAUSE, then width in PLAY.
    t_play = 0;
    for (int i = 0; i < 23; i++) begin
      pulse(vec[i].btn);
      if (vec[i].btn[0]) t_play = cyc;
      chk($sformatf("vec%0d state", i),      32'(state),      32'(vec[i].st));
      chk($sformatf("vec%0d play_pause", i), 32'(play_pause), 32'(vec[i].pp));
      chk($sformatf("vec%0d loop_de", i),    32'(loop_de),    32'(vec[i].ld));
      chk($sformatf("vec%0d loop_width", i), 32'(loop_width), 32'(vec[i].lw));
      chk($sformatf("vec%0d reverse", i),    32'(reverse),    32'(vec[i].rev));
      chk($sformatf("vec%0d tempo_div", i),  32'(tempo_div),  32'(vec[i].td));
    end
    p = t_play;
    sched(p, 8, 6);

    // Loop arm 3 cycles after the beat at p+8; LOOP follows the beat at p+16.
    idle(4);
    pulse(B_LOOP);
    chk("arm state",   32'(state),   32'd2);
    chk("arm loop_de", 32'(loop_de), 32'd0);
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("arm hold %0d state", k), 32'(state), 32'd2);
    end
    step();
    chk("loop state",      32'(state),      32'd3);
    chk("loop loop_de",    32'(loop_de),    32'd1);
    chk("loop play_pause", 32'(play_pause), 32'd1);
    pulse(B_WIDTH);
    chk("loop width frozen", 32'(loop_width), 32'd2);
    pulse(B_LOOP);
    chk("unloop state",   32'(state),   32'd1);
    chk("unloop loop_de", 32'(loop_de), 32'd0);

    // Deferred reverse: pulse at p+27 applies after the beat at p+32.
    idle(7);
    pulse(B_REV);
    chk("rev deferred", 32'(reverse), 32'd0);
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("rev hold %0d", k), 32'(reverse), 32'd0);
    end
    step();
    chk("rev applied on beat", 32'(reverse), 32'd1);
    idle(1);
    pulse(B_REV);
    idle(1);
    pulse(B_REV);
    idle(4);
    chk("rev double cancels", 32'(reverse), 32'd1);

    // Tempo shrink while cnt runs: cnt reaches 7 with tempo 6, beat at p+48.
    pulse(B_SLOW);
    chk("shrink slower1", 32'(tempo_div), 32'd10);
    pulse(B_SLOW);
    chk("shrink slower2", 32'(tempo_div), 32'd12);
    idle(1);
    pulse(B_FAST);
    chk("shrink faster1", 32'(tempo_div), 32'd10);
    pulse(B_FAST);
    chk("shrink faster2", 32'(tempo_div), 32'd8);
    pulse(B_FAST);
    chk("shrink faster3", 32'(tempo_div), 32'd6);
    chk("shrink cnt", 32'(dut.cnt_q), 32'd7);
    sched(p + 48, 6, 3);

    // ARM at p+62, LOOP after the beat at p+66, then a pending reverse.
    idle(14);
    pulse(B_LOOP);
    chk("arm2 state", 32'(state), 32'd2);
    idle(4);
    chk("arm2 hold state", 32'(state), 32'd2);
    step();
    chk("loop2 state",   32'(state),   32'd3);
    chk("loop2 loop_de", 32'(loop_de), 32'd1);
    pulse(B_REV);
    chk("loop2 rev pending", 32'(reverse), 32'd1);
    chk("loop2 beats drained", 32'(exp_beats.size()), 32'd0);

    // Asynchronous reset mid-loop restores everything at once.
    rst = 1'b0;
    #1;
    chk("arst state",      32'(state),          32'd0);
    chk("arst play_pause", 32'(play_pause),     32'd0);
    chk("arst loop_de",    32'(loop_de),        32'd0);
    chk("arst loop_width", 32'(loop_width),     32'd1);
    chk("arst reverse",    32'(reverse),        32'd0);
    chk("arst tempo_div",  32'(tempo_div),      32'd8);
    chk("arst beat_en",    32'(beat_en),        32'd0);
    chk("arst rev_pend",   32'(dut.rev_pend_q), 32'd0);
    exp_beats.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    idle(15);
    chk("post-reset idle state", 32'(state), 32'd0);
    pulse(B_PLAY);
    q0 = cyc;
    chk("replay state", 32'(state), 32'd1);
    sched(q0, 8, 2);
    idle(17);
    chk("replay beats drained", 32'(exp_beats.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
